// File: rtl/core_wb_arb_pkg.sv
// Shared constants for the writeback arbiter: datapath widths and the
// requester encoding used by the last-grant pointer.
package core_wb_arb_pkg;

  localparam int CORE_XLEN        = 32;
  localparam int CORE_RFIDX_WIDTH = 5;

  typedef enum logic {
    WB_SRC_EX  = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/gnrl_dfflr.sv
// Generic load-enabled flop with synchronous active-low reset to zero.
module gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk) begin
    if (!rst_n)    qout <= '0;
    else if (lden) qout <= dnxt;
  end

endmodule

// File: rtl/gnrl_dffr.sv
// Generic flop with synchronous active-low reset to zero.
module gnrl_dffr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk) begin
    if (!rst_n) qout <= '0;
    else        qout <= dnxt;
  end

endmodule

// File: rtl/gnrl_rr_arb2.sv
// Two-way arbiter: round-robin on contention using a last-grant pointer,
// or fixed priority to requester 1 when RR_EN is cleared.
module gnrl_rr_arb2
  import core_wb_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_nxt;

  always_comb begin
    gnt = req;
    if (req[0] & req[1]) begin
      if (RR_EN && (last_q == WB_SRC_LSU)) gnt = 2'b01;
      else                                 gnt = 2'b10;
    end
  end

  // Pointer follows every grant, contended or not.
  assign last_nxt = gnt[1] ? WB_SRC_LSU : WB_SRC_EX;

  gnrl_dfflr #(.DW(1)) u_last (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (|gnt),
    .dnxt  (last_nxt),
    .qout  (last_q)
  );

endmodule

// File: rtl/core_wb_arb.sv
// Writeback arbiter for the single RF write port shared by EX and LSU,
// with a registered write stage and a saturating contention counter.
module core_wb_arb
  import core_wb_arb_pkg::*;
#(
  parameter int XLEN    = CORE_XLEN,
  parameter int RFIDX_W = CORE_RFIDX_WIDTH,
  parameter bit RR_EN   = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic               ex_rd_wen,
  input  logic [RFIDX_W-1:0] ex_rd_idx,
  input  logic [XLEN-1:0]    ex_rd_dat,
  input  logic               lsu_valid,
  output logic               lsu_ready,
  input  logic               lsu_rd_wen,
  input  logic [RFIDX_W-1:0] lsu_rd_idx,
  input  logic [XLEN-1:0]    lsu_rd_dat,
  input  logic               cnt_clr,
  output logic               o_rf_wen,
  output logic [RFIDX_W-1:0] o_rf_waddr,
  output logic [XLEN-1:0]    o_rf_wdat,
  output logic [CNT_W-1:0]   o_conflict_cnt
);

  logic               wr_ex;
  logic               wr_lsu;
  logic [1:0]         gnt;
  logic               any_gnt;
  logic               conflict;
  logic [RFIDX_W-1:0] win_idx;
  logic [XLEN-1:0]    win_dat;
  logic [CNT_W-1:0]   cnt_nxt;

  // Writes to x0 or without rd_wen never need the port.
  assign wr_ex    = ex_valid  & ex_rd_wen  & (ex_rd_idx  != '0);
  assign wr_lsu   = lsu_valid & lsu_rd_wen & (lsu_rd_idx != '0);
  assign conflict = wr_ex & wr_lsu;

  gnrl_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({wr_lsu, wr_ex}),
    .gnt   (gnt)
  );

  assign any_gnt   = |gnt;
  assign ex_ready  = rst_n & ex_valid  & (~wr_ex  | gnt[0]);
  assign lsu_ready = rst_n & lsu_valid & (~wr_lsu | gnt[1]);

  assign win_idx = gnt[1] ? lsu_rd_idx : ex_rd_idx;
  assign win_dat = gnt[1] ? lsu_rd_dat : ex_rd_dat;

  gnrl_dffr #(.DW(1)) u_wen (
    .clk   (clk),
    .rst_n (rst_n),
    .dnxt  (any_gnt),
    .qout  (o_rf_wen)
  );

  gnrl_dfflr #(.DW(RFIDX_W)) u_waddr (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (any_gnt),
    .dnxt  (win_idx),
    .qout  (o_rf_waddr)
  );

  gnrl_dfflr #(.DW(XLEN)) u_wdat (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (any_gnt),
    .dnxt  (win_dat),
    .qout  (o_rf_wdat)
  );

  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    cnt_nxt = o_conflict_cnt;
    if (cnt_clr)
      cnt_nxt = '0;
    else if (conflict && (o_conflict_cnt != {CNT_W{1'b1}}))
      cnt_nxt = o_conflict_cnt + CNT_W'(1);
  end

  gnrl_dffr #(.DW(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .dnxt  (cnt_nxt),
    .qout  (o_conflict_cnt)
  );

endmodule
